rr_arbiter_8: RTL and testbench

- Round-robin arbiter that shares one resource between 8 requesters and issues a one-hot grant plus its 3-bit encoded index, using the same 8-to-3 encoding as the encoder datapath.
- Sits between requester blocks and the shared resource. The grant is held until the owner releases it, and priority rotates after every grant.

---
 rtl/rr_arbiter_8.sv | 205 ++++++++++++++++++++
 tb/tb_rr_arbiter_8.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: round-robin arbiter sharing one resource among 8 requesters.
//
// A grant is held until its owner drops its request. Priority rotates after
// every grant, so the requester just after the previous owner is considered
// first. A departing owner hands over directly to the next pending requester
// in the same clock edge, without an idle cycle in between.
//
// Optional feature, enabled by defining ARB_TIMEOUT_EN:
//   a hold watchdog revokes a grant after MAX_HOLD cycles. The revoked
//   requester is masked until it drops its request and raises it again.
//   Without the macro, timeout is tied low and a grant is held indefinitely.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   req[7:0]     level-sensitive request lines, one per requester
//   gnt[7:0]     registered one-hot grant
//   gnt_id[2:0]  registered encoded index of the granted requester
//   gnt_valid    high while any grant is active (equals |gnt)
//   grant_count  grants issued since reset, modulo 256
//   timeout      one-cycle pulse when the watchdog revokes a grant
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic [7:0] grant_count,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter_8: MAX_HOLD must be in 2..255");
    end

    // First set bit of r found scanning upward from 'from', wrapping 7->0.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] from);
        logic [2:0] idx;
        logic       found;
        rr_pick = from;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = from + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] i);
        onehot8 = 8'h01 << i;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;
    logic [7:0] count_q, count_d;

    logic [7:0] elig_s;
    logic [7:0] others_s;
    logic [2:0] next_ptr_s;
    logic       owner_req_s;
    logic       revoke_s;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_q, hold_d;
    logic [7:0] mask_q, mask_d;
    logic       timeout_q, timeout_d;
`endif

    // Next-state and output decode for the IDLE/BUSY grant machine.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        count_d     = count_q;
        owner_req_s = req[gnt_id_q];
        next_ptr_s  = gnt_id_q + 3'd1;
`ifdef ARB_TIMEOUT_EN
        hold_d      = hold_q;
        timeout_d   = 1'b0;
        // Mask bits clear once the masked requester lets go of its line.
        mask_d      = mask_q & req;
        elig_s      = req & ~mask_q;
        revoke_s    = (state_q == BUSY) && owner_req_s && (hold_q == 8'(MAX_HOLD - 1));
`else
        elig_s      = req;
        revoke_s    = 1'b0;
`endif
        others_s    = elig_s & ~onehot8(gnt_id_q);

        case (state_q)
            IDLE: begin
                if (elig_s != 8'h00) begin
                    gnt_id_d    = rr_pick(elig_s, ptr_q);
                    gnt_d       = onehot8(rr_pick(elig_s, ptr_q));
                    gnt_valid_d = 1'b1;
                    count_d     = count_q + 8'd1;
                    state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
                    hold_d      = 8'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!owner_req_s || revoke_s) begin
                    // Release and watchdog revoke share one hand-over path.
                    ptr_d = next_ptr_s;
`ifdef ARB_TIMEOUT_EN
                    if (revoke_s) begin
                        timeout_d = 1'b1;
                        mask_d    = (mask_q & req) | onehot8(gnt_id_q);
                    end else begin
                        timeout_d = 1'b0;
                    end
`endif
                    if (others_s != 8'h00) begin
                        gnt_id_d    = rr_pick(others_s, next_ptr_s);
                        gnt_d       = onehot8(rr_pick(others_s, next_ptr_s));
                        gnt_valid_d = 1'b1;
                        count_d     = count_q + 8'd1;
                        state_d     = BUSY;
`ifdef ARB_TIMEOUT_EN
                        hold_d      = 8'd0;
`endif
                    end else begin
                        // gnt_id deliberately keeps the last owner.
                        gnt_d       = 8'h00;
                        gnt_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else begin
`ifdef ARB_TIMEOUT_EN
                    hold_d = hold_q + 8'd1;
`endif
                    state_d = BUSY;
                end
            end
            default: begin
                gnt_d       = 8'h00;
                gnt_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, pointer and registered grant outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= 3'd0;
            gnt_q       <= 8'h00;
            gnt_id_q    <= 3'd0;
            gnt_valid_q <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            count_q     <= count_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Watchdog hold counter, revoke mask and timeout pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= 8'd0;
            mask_q    <= 8'h00;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            mask_q    <= mask_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt         = gnt_q;
    assign gnt_id      = gnt_id_q;
    assign gnt_valid   = gnt_valid_q;
    assign grant_count = count_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Self-checking bench for rr_arbiter_8: directed scenarios with literal
// expectations plus randomized request traffic compared every cycle against
// a behavioural owner/pointer model.
module tb_rr_arbiter_8;

    localparam int MAX_HOLD_TB = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic [7:0] grant_count;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    rr_arbiter_8 #(.MAX_HOLD(MAX_HOLD_TB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .gnt_valid  (gnt_valid),
        .grant_count(grant_count),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_owner;   // -1 when nobody holds the resource
    int         m_ptr;
    int         m_last;
    int         m_count;
    int         m_hold;
    logic       m_tmo;
    logic [7:0] m_mask;

    function automatic int pick(input logic [7:0] r, input int from);
        for (int k = 0; k < 8; k++) begin
            if (r[(from + k) % 8]) return (from + k) % 8;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int o, p, c, h;
        logic t, rel, rev;
        logic [7:0] elig, others, mk;
        if (!rst_n) begin
            m_owner <= -1; m_ptr <= 0; m_last <= 0; m_count <= 0;
            m_hold  <= 0;  m_tmo <= 1'b0; m_mask <= 8'h00;
        end else begin
            o = m_owner; p = m_ptr; c = m_count; h = m_hold; t = 1'b0;
            mk = m_mask & req;
`ifdef ARB_TIMEOUT_EN
            elig = req & ~m_mask;
`else
            elig = req;
`endif
            if (o < 0) begin
                if (elig != 8'h00) begin
                    o = pick(elig, p); c = (c + 1) % 256; h = 0;
                end
            end else begin
                rel = !req[o];
                rev = 1'b0;
`ifdef ARB_TIMEOUT_EN
                rev = req[o] && (h == MAX_HOLD_TB - 1);
`endif
                if (rel || rev) begin
                    p = (o + 1) % 8;
                    others = elig & ~(8'h01 << o);
                    if (rev) begin t = 1'b1; mk[o] = 1'b1; end
                    if (others != 8'h00) begin
                        o = pick(others, p); c = (c + 1) % 256; h = 0;
                    end else begin
                        o = -1;
                    end
                end else begin
                    h = h + 1;
                end
            end
            m_owner <= o; m_ptr <= p; m_count <= c; m_hold <= h;
            m_tmo <= t; m_mask <= mk;
            if (o >= 0) m_last <= o;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin : compare
        logic [7:0] e_gnt;
        if (started && rst_n) begin
            e_gnt = (m_owner >= 0) ? (8'h01 << m_owner) : 8'h00;
            n_cmp++;
            if (gnt !== e_gnt || gnt_id !== 3'(m_last) || gnt_valid !== (m_owner >= 0) ||
                grant_count !== 8'(m_count) || timeout !== m_tmo) begin
                n_bad++;
                $display("FAIL model t=%0t: got gnt=%h id=%0d v=%b cnt=%0d to=%b expected gnt=%h id=%0d v=%b cnt=%0d to=%b",
                         $time, gnt, gnt_id, gnt_valid, grant_count, timeout,
                         e_gnt, m_last, (m_owner >= 0), m_count, m_tmo);
            end
        end
    end

    // Asserts reset mid-cycle, checks the asynchronous clear, then releases.
    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_gnt_id", 32'(gnt_id), 32'h0);
        chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
        chk("rst_grant_count", 32'(grant_count), 32'h0);
        chk("rst_timeout", 32'(timeout), 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : stim
        logic [7:0] bitk;
        rst_n = 1'b1;
        req   = 8'h00;
        #3 rst_n = 1'b0;
        do_reset();
        started = 1'b1;

        // Single request and release.
        req = 8'h10;
        @(posedge clk); #1;
        chk("single_gnt", 32'(gnt), 32'h10);
        chk("single_id", 32'(gnt_id), 32'd4);
        chk("single_valid", 32'(gnt_valid), 32'd1);
        #1 req = 8'h00;
        @(posedge clk); #1;
        chk("release_gnt", 32'(gnt), 32'h0);
        chk("release_valid", 32'(gnt_valid), 32'd0);
        chk("release_id_kept", 32'(gnt_id), 32'd4);
        #1;

        // Round-robin with all requesters, reset asserted while req is all-ones.
        req = 8'hFF;
        do_reset();
        for (int k = 0; k < 9; k++) begin
            @(posedge clk); #1;
            chk("rr_id", 32'(gnt_id), 32'(k % 8));
            chk("rr_count", 32'(grant_count), 32'(k + 1));
            chk("rr_valid", 32'(gnt_valid), 32'd1);
            bitk = 8'h01 << (k % 8);
            #1 req = 8'hFF & ~bitk;
        end

        // Wrap and priority: owner 6 releases with 7 and 0 pending.
        req = 8'h00;
        do_reset();
        req = 8'h40;
        @(posedge clk); #1;
        chk("wrap_first_id", 32'(gnt_id), 32'd6);
        #1 req = 8'h81;
        @(posedge clk); #1;
        chk("wrap_prio_id", 32'(gnt_id), 32'd7);
        #1 req = 8'h01;
        @(posedge clk); #1;
        chk("wrap_after7_id", 32'(gnt_id), 32'd0);
        #1;

        // Grant counter wrap over 256 back-to-back grants.
        req = 8'h00;
        do_reset();
        req = 8'h01;
        for (int n = 1; n <= 256; n++) begin
            @(posedge clk); #1;
            if (n == 255) chk("count_255", 32'(grant_count), 32'd255);
            if (n == 256) chk("count_wrap", 32'(grant_count), 32'd0);
            #1 req = (n % 2 == 1) ? 8'h02 : 8'h01;
        end

`ifdef ARB_TIMEOUT_EN
        // Watchdog revoke of a permanently held request.
        req = 8'h00;
        do_reset();
        req = 8'h24;
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            chk("hold_id2", 32'(gnt_id), 32'd2);
            chk("hold_no_timeout", 32'(timeout), 32'd0);
            #1;
        end
        @(posedge clk); #1;
        chk("revoke_id5", 32'(gnt_id), 32'd5);
        chk("revoke_timeout", 32'(timeout), 32'd1);
        #1 req = 8'h04;
        @(posedge clk); #1;
        chk("timeout_pulse_end", 32'(timeout), 32'd0);
        chk("masked_idle", 32'(gnt_valid), 32'd0);
        #1 req = 8'h00;
        @(posedge clk); #2 req = 8'h04;
        @(posedge clk); #1;
        chk("regrant_id2", 32'(gnt_id), 32'd2);
        chk("regrant_valid", 32'(gnt_valid), 32'd1);
        #1;
`endif

        // Randomized traffic checked by the model, with two mid-run resets.
        req = 8'h00;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #2;
            for (int b = 0; b < 8; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            if (c == 700 || c == 1400) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
